// File: rtl/div_pkg.sv
// Shared types and helpers for the iterative DIV/DIVU datapath.
package div_pkg;

    localparam int unsigned DIV_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FIXUP = 2'd2
    } div_state_t;

    // Magnitude of an operand; two's complement negation only for signed negatives.
    function automatic logic [DIV_W-1:0] abs_val(input logic [DIV_W-1:0] x,
                                                 input logic             signed_en);
        if (signed_en && x[DIV_W-1]) begin
            return DIV_W'(0) - x;
        end
        return x;
    endfunction

endpackage

// File: rtl/div_iterate.sv
// Restoring shift-subtract divider: one quotient bit per clock, HI/LO results.
module div_iterate
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_W,
    localparam int unsigned SHW  = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             dvrst,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic [WIDTH-1:0] shiftb,
    input  logic [SHW-1:0]   shamt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    div_state_t       state_q, state_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic             dz_q, dz_d;
    logic             skip_q, skip_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rmd_q, rmd_d;

    logic [WIDTH-1:0] abs_dd_c;
    logic [WIDTH-1:0] abs_dv_c;
    logic             dz_c;

    // Operand magnitudes and the short-path decisions made at accept time.
    always_comb begin
        abs_dd_c = WIDTH'(abs_val(DIV_W'(dividend), is_signed));
        abs_dv_c = WIDTH'(abs_val(DIV_W'(divisor), is_signed));
        dz_c     = (divisor == '0);
    end

    // Next-state and datapath updates for the accept / iterate / fix-up sequence.
    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        dvs_d     = dvs_q;
        cnt_d     = cnt_q;
        q_d       = q_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        dz_d      = dz_q;
        skip_d    = skip_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        quo_d     = quo_q;
        rmd_d     = rmd_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    rem_d     = abs_dd_c;
                    dvs_d     = shiftb;
                    cnt_d     = shamt;
                    q_d       = '0;
                    neg_quo_d = is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                    neg_rem_d = is_signed & dividend[WIDTH-1];
                    dz_d      = dz_c;
                    busy_d    = 1'b1;
                    if (dz_c || (abs_dv_c > abs_dd_c)) begin
                        skip_d  = 1'b1;
                        state_d = FIXUP;
                    end else begin
                        skip_d  = 1'b0;
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (rem_q >= dvs_q) begin
                    rem_d = rem_q - dvs_q;
                    q_d   = q_q | (WIDTH'(1) << cnt_q);
                end
                dvs_d = dvs_q >> 1;
                if (cnt_q == '0) begin
                    state_d = FIXUP;
                end else begin
                    cnt_d = cnt_q - SHW'(1);
                end
            end
            FIXUP: begin
                // Short paths linger one cycle here so they complete two edges after accept.
                if (skip_q) begin
                    skip_d = 1'b0;
                end else begin
                    if (dz_q) begin
                        quo_d = '1;
                    end else if (neg_quo_q) begin
                        quo_d = WIDTH'(0) - q_q;
                    end else begin
                        quo_d = q_q;
                    end
                    // rem holds |dividend| on both short paths, so this restores the raw dividend.
                    rmd_d   = neg_rem_q ? (WIDTH'(0) - rem_q) : rem_q;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge dvrst) begin
        if (dvrst) begin
            state_q   <= IDLE;
            rem_q     <= '0;
            dvs_q     <= '0;
            cnt_q     <= '0;
            q_q       <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
            skip_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            quo_q     <= '0;
            rmd_q     <= '0;
        end else begin
            state_q   <= state_d;
            rem_q     <= rem_d;
            dvs_q     <= dvs_d;
            cnt_q     <= cnt_d;
            q_q       <= q_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            dz_q      <= dz_d;
            skip_q    <= skip_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            quo_q     <= quo_d;
            rmd_q     <= rmd_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign quotient  = quo_q;
    assign remainder = rmd_q;

endmodule
